div_unit: RTL
=============

Name: div_unit

Overview:
- Parametrised multi-cycle integer divider for the EX stage of the OpenMIPS pipeline.
- Serves DIV/DIVU; ex holds it via start/annul and raises stallreq_from_ex while it is busy.
- Result returns as a {remainder, quotient} pair destined for HI/LO.
- Successor to the fixed-width multi-cycle EX arithmetic: width-generic, signed/unsigned mode, defined divide-by-zero, cancellation on flush.

Parameters:
- WIDTH, 32, operand width in bits (>= 4); result is 2*WIDTH.
- CNT_W, $clog2(WIDTH+1), step-counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- signed_div_i  in  1  1 = two's-complement divide, 0 = unsigned; sampled with start_i
- opdata1_i  in  WIDTH  dividend; sampled with start_i
- opdata2_i  in  WIDTH  divisor; sampled with start_i
- start_i  in  1  request; must stay high until ready_o seen
- annul_i  in  1  cancel (pipeline flush)
- busy_o  out  1  1 in any state other than FREE
- ready_o  out  1  result valid
- result_o  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}

Behaviour:
- Reset (async, rst_n=0): state=FREE, counter=0, ready_o=0, busy_o=0, result_o=0, internal regs=0.
- FSM states and transitions:
  - FREE:
    - start_i=1 && annul_i=0 && opdata2_i==0 -> BY_ZERO.
    - start_i=1 && annul_i=0 && opdata2_i!=0 -> ON: latch |dividend|, |divisor| (absolute values only when signed_div_i=1), latch sign flags, counter=0.
    - otherwise stay in FREE.
  - ON:
    - One restoring step per cycle: shift partial remainder left 1 bit, bring in the next dividend MSB, trial-subtract the divisor. If no borrow, keep the difference and shift a 1 into the quotient; else shift a 0. Counter increments.
    - When counter==WIDTH -> END: apply sign correction and register result_o.
    - annul_i=1 -> FREE, no result.
  - BY_ZERO: next edge -> END with quotient = all ones, remainder = opdata1_i as latched (raw, uncorrected). annul_i=1 -> FREE instead.
  - END: ready_o=1, result_o stable. start_i=0 -> FREE with ready_o=0 and result_o=0. annul_i=1 also -> FREE. start_i held high keeps the unit in END.
- Latency:
  - Nonzero divisor: ready_o rises on edge WIDTH+1 after the edge that sampled start_i (33 cycles for WIDTH=32).
  - Zero divisor: ready_o rises on edge 2.
- Sign rules (signed_div_i=1):
  - Quotient is negated when the operand signs differ; remainder takes the sign of the dividend (truncating division).
  - Most-negative / -1: quotient = most-negative value (wraps), remainder = 0. No exception.
- Width rules: all internal arithmetic is WIDTH+1 bits for the trial subtract; the absolute value of the most-negative value is treated as unsigned 2^(WIDTH-1).
- Simultaneous events:
  - In FREE, start_i && annul_i -> annul wins, stay FREE.
  - start_i rising while busy_o=1 -> ignored; operands are not re-sampled.
  - Operand inputs changing after sampling -> no effect.
  - annul_i in the same cycle the FSM would enter END -> FREE, ready_o stays 0.
- Reset asserted mid-operation -> immediate return to reset values, regardless of state.
- busy_o is combinational from the state register (for stall generation). ready_o and result_o are registered.

Test Plan:
- Unsigned, WIDTH=32: 100/7, start held -> ready_o at edge 33, result_o = {32'd2, 32'd14}; drop start -> next edge ready_o=0, result_o=0, busy_o=0.
- Signed: -7/2 -> {32'hFFFFFFFF, 32'hFFFFFFFD} (rem -1, quo -3); 7/-2 -> {32'd1, 32'hFFFFFFFD}; 0x80000000/-1 -> {0, 32'h80000000}.
- Divide by zero: 0x1234/0, unsigned -> ready_o at edge 2, result_o = {32'h00001234, 32'hFFFFFFFF}.
- Annul at step 10 of 100/7 -> FREE next edge, ready_o never rises; immediate new start 9/3 -> {0, 3} at edge 33.
- Async reset mid-ON (rst_n low between edges) -> outputs 0 at once; a start_i pulse of one cycle while busy, and start&&annul in FREE -> both ignored.
- Parameter sweep WIDTH=8: 255/16 unsigned -> {8'd15, 8'd15} at edge 9; signed -128/-1 -> {8'd0, 8'h80}.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient}; signed mode truncates toward zero.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_BY_ZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dq_q, dq_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               ready_q, ready_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   trial;
    logic               borrow;
    logic [WIDTH-1:0]   rem_step, quo_step;
    logic               last_step;

    // dq_q holds the dividend bits still to be consumed and collects quotient bits from the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dq_q      <= '0;
            div_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dq_q      <= dq_d;
            div_q     <= div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FREE: begin
                if (start_i && !annul_i)
                    state_d = (opdata2_i == '0) ? S_BY_ZERO : S_ON;
            end
            S_BY_ZERO: state_d = annul_i ? S_FREE : S_END;
            S_ON: begin
                if (annul_i)
                    state_d = S_FREE;
                else if (last_step)
                    state_d = S_END;
            end
            S_END: begin
                if (annul_i || !start_i)
                    state_d = S_FREE;
            end
            default: state_d = S_FREE;
        endcase
    end

    // The most-negative value negates to itself, which reads correctly as unsigned 2^(WIDTH-1).
    assign abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    assign shifted  = {rem_q, dq_q[WIDTH-1]};
    assign trial    = {1'b0, shifted} - {2'b00, div_q};
    assign borrow   = trial[WIDTH+1];
    assign rem_step = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_step = {dq_q[WIDTH-2:0], ~borrow};

    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dq_d      = dq_q;
        div_d     = div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        ready_d   = 1'b0;
        result_d  = '0;
        case (state_q)
            S_FREE: begin
                if (start_i && !annul_i) begin
                    cnt_d     = '0;
                    rem_d     = '0;
                    dq_d      = (opdata2_i == '0) ? opdata1_i : abs1;
                    div_d     = abs2;
                    neg_quo_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_rem_d = signed_div_i && opdata1_i[WIDTH-1];
                end
            end
            S_BY_ZERO: begin
                rem_d = dq_q;
                dq_d  = '1;
            end
            S_ON: begin
                if (!annul_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_step) begin
                        rem_d = neg_rem_q ? -rem_step : rem_step;
                        dq_d  = neg_quo_q ? -quo_step : quo_step;
                    end else begin
                        rem_d = rem_step;
                        dq_d  = quo_step;
                    end
                end
            end
            S_END: begin
                if (!annul_i && start_i) begin
                    ready_d  = 1'b1;
                    result_d = {rem_q, dq_q};
                end
            end
            default: ;
        endcase
    end

    assign busy_o   = (state_q != S_FREE);
    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule
